// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types; the fetch stage uses the fetch FSM state and
// the fetch constants below.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [3:0]  IMEM_MASK_WORD = 4'hf;
    localparam logic [3:0]  IMEM_MASK_NONE = 4'h0;
    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK  = 32'hffff_fffc;

endpackage

// File: rtl/fetch_stage.sv
// In-order fetch: owns the fetch PC, keeps one imem read in flight, buffers one
// fetched word for decode and squashes responses made stale by a redirect.
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_rdata,
    output logic [31:0] fetch_pc
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_bufValid;
    logic [31:0]  r_bufInst;
    logic [31:0]  r_bufPc;

    logic [31:0]  w_redirPc;
    logic         w_transfer;
    logic         w_issue;

    assign w_redirPc  = redirect_pc & PC_ALIGN_MASK;
    assign w_transfer = fetch_valid & fetch_ready;

    // A new request may only go out when the output buffer will have room for its reply.
    assign w_issue = rst && (r_state == IDLE) && !redirect_valid
                     && (!r_bufValid || w_transfer);

    assign imem_addr   = r_pc;
    assign imem_rmask  = w_issue ? IMEM_MASK_WORD : IMEM_MASK_NONE;
    assign fetch_valid = r_bufValid & ~redirect_valid;
    assign fetch_rdata = r_bufInst;
    assign fetch_pc    = r_bufPc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_bufValid <= 1'b0;
            r_bufInst  <= 32'h0;
            r_bufPc    <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect_valid) begin
                        r_pc       <= w_redirPc;
                        r_bufValid <= 1'b0;
                    end else begin
                        if (w_transfer) begin
                            r_bufValid <= 1'b0;
                        end
                        if (w_issue) begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Without a response the request is still in flight, so it must be drained.
                    if (redirect_valid) begin
                        r_pc       <= w_redirPc;
                        r_bufValid <= 1'b0;
                        r_state    <= imem_resp ? IDLE : DRAIN;
                    end else if (imem_resp) begin
                        r_bufInst  <= imem_rdata;
                        r_bufPc    <= r_pc;
                        r_bufValid <= 1'b1;
                        r_pc       <= r_pc + PC_STEP;
                        r_state    <= IDLE;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        r_pc       <= w_redirPc;
                        r_bufValid <= 1'b0;
                    end
                    if (imem_resp) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_bufValid <= 1'b0;
                end
            endcase
        end
    end

    // Memory must never answer when nothing is outstanding.
    a_noRespInIdle: assert property (@(posedge clk) disable iff (!rst)
        !((r_state == IDLE) && imem_resp));

    a_bufEmptyWhileBusy: assert property (@(posedge clk) disable iff (!rst)
        (r_state != IDLE) |-> !r_bufValid);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

In-order instruction fetch unit that owns the architectural fetch PC, issues single-word reads to instruction memory, and delivers `{instruction word, PC}` pairs to `id_stage` through a valid/ready handshake. It sits between the imem port and the decode stage, on the transmitter side of decode's `imem_rdata`/`pc_curr` inputs. It honours redirects from branch/jump resolution and flush. It keeps at most one memory request outstanding, holds fetched words in a one-entry output register, and discards stale responses after a redirect.

## Interface
- `RESET_PC`, default `32'h1eceb000`: fetch PC loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  32  word-aligned read address; equals the fetch PC register.
- `imem_rmask`  out  4  `4'hf` for exactly one cycle per request; `4'h0` otherwise.
- `imem_rdata`  in  32  read data; valid only when `imem_resp`=1.
- `imem_resp`  in  1  single-cycle response strobe for the outstanding request.
- `redirect_valid`  in  1  flush fetch and restart at `redirect_pc`.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] are forced to 0 internally.
- `fetch_valid`  out  1  output register holds an instruction: `buf_valid & ~redirect_valid`.
- `fetch_ready`  in  1  decode/instruction queue accepts the word this cycle.
- `fetch_rdata`  out  32  instruction word; drives `id_stage.imem_rdata`.
- `fetch_pc`  out  32  PC of `fetch_rdata`; drives `id_stage.pc_curr`.

## Operation
- Registers:
  - `pc`: fetch PC.
  - `state`: one of IDLE, WAIT, DRAIN.
  - Output buffer: `buf_valid`, `buf_inst`, `buf_pc`.
- Transfer: occurs when `fetch_valid & fetch_ready`. It frees the buffer in the same cycle.
- IDLE (no request outstanding):
  - If `redirect_valid`: `pc`←`redirect_pc`, clear `buf_valid`, stay IDLE, no request.
  - Else, if the buffer is empty or transferring this cycle: `imem_rmask`=`4'hf` with `imem_addr`=`pc`, then go to WAIT.
  - Else: stay IDLE with `rmask`=0.
- WAIT (request outstanding):
  - If `imem_resp & ~redirect_valid`:
    - load `buf_inst`←`imem_rdata`, `buf_pc`←`pc`, set `buf_valid`;
    - `pc`←`pc+4` (32-bit, wraps modulo 2^32);
    - go to IDLE.
    - The buffer always has room here, because a request is only issued when the buffer is empty or draining.
  - If `imem_resp & redirect_valid`: drop the data, `pc`←`redirect_pc`, clear `buf_valid`, go to IDLE.
  - If `~imem_resp & redirect_valid`: `pc`←`redirect_pc`, clear `buf_valid`, go to DRAIN.
- DRAIN (stale request outstanding):
  - No new request is issued.
  - On `imem_resp`: discard the data and go to IDLE.
  - `redirect_valid` in DRAIN: update `pc` and clear the buffer (it is already empty); stay in DRAIN. If it coincides with `imem_resp`, go to IDLE with the new `pc`.
- Redirect has priority over every other event. A word presented in the redirect cycle is never transferred, because `fetch_valid` is gated.
- `imem_addr` is driven from `pc` in every state. It is stable across WAIT because `pc` only changes on resp or redirect.
- `imem_resp` arriving in IDLE is a protocol error. It is ignored, and an assertion fires in simulation.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state IDLE, `buf_valid`=0, `buf_inst`=0, `buf_pc`=0;
  - outputs `imem_addr`=`RESET_PC`, `imem_rmask`=0, `fetch_valid`=0, `fetch_rdata`=0, `fetch_pc`=0.
- Reset takes effect immediately and asynchronously, including mid-request. A response arriving after reset deasserts, for a request issued before reset, is unsupported; the memory model is reset concurrently.
- First request: the first rising edge after `rst` deasserts sees IDLE, so `rmask`=`4'hf` in that cycle.
- Request in cycle t with resp in t+L: `fetch_valid`=1 in t+L+1. If `fetch_ready` is 1 in t+L+1, the next request issues in t+L+1.
- Steady-state throughput: one instruction per L+1 cycles.
- Redirect in cycle r:
  - `fetch_valid`=0 in r and r+1.
  - If not in DRAIN at r+1, the request to `redirect_pc` issues in r+1.
  - Otherwise, it issues in the cycle after the stale resp.
- Backpressure: `fetch_valid`, `fetch_rdata` and `fetch_pc` hold stable until transfer or redirect.

## Structure
- Add `fetch_state_t` (IDLE, WAIT, DRAIN) to `rv32i_types`. `RESET_PC` remains a module parameter.
- Single module; no sub-module is needed. The one-entry output register lives inline.

## Test plan
- Reset, memory latency L=2, `fetch_ready`=1 → `rmask`=`f` at cycle 0 with addr `1eceb000`. Cycle 3: `fetch_valid`=1, `fetch_pc`=`1eceb000`. Cycle 3: next request to `1eceb004`.
- `fetch_ready`=0 for 10 cycles after the first word → `fetch_valid`/`fetch_pc`/`fetch_rdata` stable and no new `rmask` pulse. Release `ready` → `rmask` in the same cycle to `+4`.
- Redirect to `0x00000100` mid-WAIT, stale resp 3 cycles later → stale data never appears on `fetch_valid`. The request to `0x100` issues the cycle after the stale resp, and the first output has `fetch_pc`=`0x100`.
- Redirect coincident with `imem_resp` and with `fetch_valid & fetch_ready` → no transfer, data dropped, next request to `redirect_pc` in the following cycle.
- `redirect_pc`=`0x103` → `imem_addr`=`0x100`. Fetch at `pc`=`0xfffffffc` → the next address is `0x00000000`.
- Assert `rst` low during WAIT → all outputs take their reset values immediately. After release, the request resumes at `RESET_PC`.
